branch_ctrl: RTL and testbench
==============================

Name: branch_ctrl

Overview:
- Resolves branches in the decode stage. Drives the fetch stage's PC-control inputs: instruction_fetch_en, branch_taken and branch_offset_imm.
- Squashes the wrong-path instructions already fetched, using an IF/ID flush.
- Sits between the ID stage, the hazard detection unit and the PC/fetch logic.
- Keeps a count of taken branches for performance debug.

Parameters:
- PC_WIDTH, 8, width of the program counter; taken_count also wraps at 16 bits independent of this.
- FLUSH_CYCLES, 2, number of IF/ID flush cycles after a redirect (range 1..7).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- id_valid  in  1  ID stage holds a real (non-bubble) instruction.
- id_instruction  in  16  instruction in ID; [15:12] opcode, [11:9] rs, [5:0] signed imm.
- rs_data  in  16  forwarded value of register rs.
- hazard_stall  in  1  load-use stall request from hazard unit.
- instruction_fetch_en  out  1  PC advance enable.
- branch_taken  out  1  one-cycle redirect pulse to PC logic.
- branch_offset_imm  out  6  signed PC offset, valid while branch_taken=1.
- if_id_flush  out  1  invalidate IF/ID register this cycle.
- taken_count  out  16  count of redirects issued since reset.

Behaviour:
- Reset: synchronous, active-high; takes effect at a clk edge with rst=1.
  - All registers clear: state=RUN, branch_taken=0, branch_offset_imm=0, if_id_flush=0, taken_count=0, started=0.
  - instruction_fetch_en=0 while rst=1 and for the first cycle after release (started=0).
  - Reset mid-redirect or mid-flush aborts it; no pulse survives reset.
- started: set on the first clk edge with rst=0, and stays set.
- instruction_fetch_en is combinational: started && (state!=RUN || !hazard_stall).
- branch_taken, branch_offset_imm and if_id_flush are registered; each is 0 unless stated below.
- Branch decode, using opcode constants from the shared defines:
  - BZ: taken if rs_data==16'h0.
  - BNZ: taken if rs_data!=16'h0.
  - JMP: always taken.
  - Any other opcode: not a branch.
- take = id_valid && is_branch && cond && !hazard_stall.
- FSM states RUN, REDIRECT, FLUSH:
  - RUN, take=0: stay in RUN, outputs 0.
  - RUN, take=1: next state REDIRECT. Register branch_offset_imm=id_instruction[5:0], branch_taken=1, if_id_flush=1; taken_count+1.
  - RUN with hazard_stall=1: branch evaluation is deferred (operand not ready) and fetch_en=0; the branch is re-evaluated when the stall drops.
  - REDIRECT, one cycle: branch_taken=1, fetch_en=1, so the PC takes pc+sext(offset). Next state FLUSH with cnt=FLUSH_CYCLES-1; if_id_flush=1.
  - FLUSH: if_id_flush=1, fetch_en=1. id_valid and hazard_stall are ignored, so wrong-path branches are never taken. cnt decrements each cycle; at cnt==0 the next state is RUN.
- Latency:
  - Branch in ID at cycle N gives branch_taken=1 at N+1 and the PC updated at the N+1 edge.
  - The first target instruction reaches ID at N+2+FLUSH_CYCLES-1.
- hazard_stall in REDIRECT/FLUSH: ignored; the redirect has priority.
- Back-to-back branches: the second is in the flushed shadow and is never taken.
- taken_count wraps 16'hFFFF -> 0.
- branch_offset_imm holds its last value when branch_taken=0.

Decomposition:
- Shared defines header (mips_16_defs.v): OP_BZ, OP_BNZ, OP_JMP opcode constants, PC_WIDTH, and state encodings RUN=2'd0, REDIRECT=2'd1, FLUSH=2'd2.
- One natural sub-module, branch_cond: a combinational decoder from opcode and rs_data to is_branch and cond.

Test Plan:
- Reset, then release with no branches -> fetch_en=0 in the first cycle after release, then 1; taken_count=0; all pulses 0.
- BZ with rs_data=0, imm=6'h3C (-4), id_valid=1 -> branch_taken=1 for exactly 1 cycle with offset=6'h3C; if_id_flush=1 for 1+FLUSH_CYCLES cycles; taken_count=1.
- BNZ with rs_data=0 -> no redirect and no flush; fetch_en stays 1.
- BZ with rs_data=0 while hazard_stall=1 for 2 cycles -> fetch_en=0 and no pulse during the stall; branch_taken=1 in the cycle after the stall drops.
- JMP followed immediately by a BZ (rs_data=0) in the shadow -> exactly one branch_taken pulse; taken_count increments by 1.
- rst asserted in the FLUSH state -> all outputs 0 next cycle; after release, normal fetch resumes with a 1-cycle fetch_en delay.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// branch_ctrl_pkg: shared opcodes, FSM encoding and defaults for the decode-stage branch controller
package branch_ctrl_pkg;
    localparam int DEF_PC_WIDTH = 8;
    localparam int DEF_FLUSH_CYCLES = 2;
    localparam int CNT_W = 3;
    localparam logic [3:0] OP_BZ = 4'h8;
    localparam logic [3:0] OP_BNZ = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    typedef enum logic [1:0] {RUN = 2'd0, REDIRECT = 2'd1, FLUSH = 2'd2} state_t;
    function automatic logic [5:0] imm_of(input logic [15:0] instr);
        return instr[5:0];
    endfunction
endpackage

// File: rtl/branch_ctrl_if.sv
// branch_ctrl_if: ID-stage inputs and fetch-control outputs of the branch controller
interface branch_ctrl_if;
    logic        id_valid;
    logic [15:0] id_instruction;
    logic [15:0] rs_data;
    logic        hazard_stall;
    logic        instruction_fetch_en;
    logic        branch_taken;
    logic [5:0]  branch_offset_imm;
    logic        if_id_flush;
    logic [15:0] taken_count;
    modport master (
        output id_valid, id_instruction, rs_data, hazard_stall,
        input  instruction_fetch_en, branch_taken, branch_offset_imm, if_id_flush, taken_count
    );
    modport slave (
        input  id_valid, id_instruction, rs_data, hazard_stall,
        output instruction_fetch_en, branch_taken, branch_offset_imm, if_id_flush, taken_count
    );
endinterface

// File: rtl/branch_ctrl_cond.sv
// branch_cond: decodes opcode and rs value into is_branch and branch condition
module branch_cond
    import branch_ctrl_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [15:0] rs_data,
    output logic        is_branch,
    output logic        cond
);
    logic zero;
    always_comb begin
        zero = rs_data == 16'h0;
        is_branch = opcode == OP_BZ || opcode == OP_BNZ || opcode == OP_JMP;
        cond = opcode == OP_BZ ? zero : opcode == OP_BNZ ? !zero : opcode == OP_JMP;
    end
endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: resolves branches in ID, redirects fetch and flushes the wrong-path IF/ID slots
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int PC_WIDTH = DEF_PC_WIDTH,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
    input logic clk,
    input logic rst,
    branch_ctrl_if.slave bus
);
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7 || PC_WIDTH < 6) begin : g_bad_param
        $error("branch_ctrl: FLUSH_CYCLES must be 1..7 and PC_WIDTH at least 6");
    end
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic branch_taken_q, branch_taken_d;
    logic [5:0] offset_q, offset_d;
    logic flush_q, flush_d;
    logic [15:0] count_q, count_d;
    logic started_q, started_d;
    logic is_branch, cond, take;
    logic unused_rs_field;
    assign unused_rs_field = ^bus.id_instruction[11:6];
    branch_cond u_cond (
        .opcode    (bus.id_instruction[15:12]),
        .rs_data   (bus.rs_data),
        .is_branch (is_branch),
        .cond      (cond)
    );
    // Stall and ID contents only matter in RUN; the redirect shadow ignores them.
    always_comb begin
        take = state_q == RUN && bus.id_valid && is_branch && cond && !bus.hazard_stall;
        state_d = take ? REDIRECT :
                  state_q == REDIRECT ? FLUSH :
                  (state_q == FLUSH && cnt_q != '0) ? FLUSH : RUN;
        cnt_d = state_q == REDIRECT ? CNT_W'(FLUSH_CYCLES - 1) :
                state_q == FLUSH ? cnt_q - 1'b1 : cnt_q;
        branch_taken_d = take;
        offset_d = take ? imm_of(bus.id_instruction) : offset_q;
        flush_d = state_d != RUN;
        count_d = count_q + 16'(take);
        started_d = 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q <= '0;
            branch_taken_q <= 1'b0;
            offset_q <= '0;
            flush_q <= 1'b0;
            count_q <= '0;
            started_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            branch_taken_q <= branch_taken_d;
            offset_q <= offset_d;
            flush_q <= flush_d;
            count_q <= count_d;
            started_q <= started_d;
        end
    end
    assign bus.instruction_fetch_en = !rst && started_q && (state_q != RUN || !bus.hazard_stall);
    assign bus.branch_taken = branch_taken_q;
    assign bus.branch_offset_imm = offset_q;
    assign bus.if_id_flush = flush_q;
    assign bus.taken_count = count_q;
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: scoreboard bench comparing branch_ctrl against a cycle model of the redirect shadow
module tb_branch_ctrl;
    import branch_ctrl_pkg::*;
    localparam int FC = 2;
    typedef struct {
        logic        bt;
        logic [5:0]  off;
        logic        fl;
        logic [15:0] cnt;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    int shadow = 0;
    logic m_started = 1'b0;
    logic [5:0] m_off = '0;
    logic [15:0] m_cnt = '0;
    branch_ctrl_if bus ();
    branch_ctrl #(.PC_WIDTH(8), .FLUSH_CYCLES(FC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic is_taken(input logic [15:0] instr, input logic [15:0] rs);
        case (instr[15:12])
            OP_BZ:   return rs == 16'h0;
            OP_BNZ:  return rs != 16'h0;
            OP_JMP:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
    function automatic logic [15:0] mk(input logic [3:0] op, input logic [5:0] imm);
        return {op, 3'd1, 3'd0, imm};
    endfunction
    task automatic cycle(input logic v, input logic [15:0] instr, input logic [15:0] rs,
                         input logic stall, input logic r);
        exp_t e;
        logic take;
        @(negedge clk);
        rst = r;
        bus.id_valid = v;
        bus.id_instruction = instr;
        bus.rs_data = rs;
        bus.hazard_stall = stall;
        #1;
        chk("fetch_en", 32'(bus.instruction_fetch_en), 32'(!r && m_started && (shadow != 0 || !stall)));
        take = !r && shadow == 0 && v && is_taken(instr, rs) && !stall;
        if (r) begin
            shadow = 0;
            m_started = 1'b0;
            m_off = '0;
            m_cnt = '0;
        end else begin
            m_started = 1'b1;
            if (take) begin
                shadow = 1 + FC;
                m_off = instr[5:0];
                m_cnt = m_cnt + 16'd1;
            end else if (shadow > 0) begin
                shadow = shadow - 1;
            end
        end
        e.bt = take;
        e.off = m_off;
        e.fl = shadow > 0 && !take ? 1'b1 : take;
        e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("branch_taken", 32'(bus.branch_taken), 32'(e.bt));
            chk("offset", 32'(bus.branch_offset_imm), 32'(e.off));
            chk("if_id_flush", 32'(bus.if_id_flush), 32'(e.fl));
            chk("taken_count", 32'(bus.taken_count), 32'(e.cnt));
        end
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    endtask
    initial begin
        bus.id_valid = 1'b0;
        bus.id_instruction = '0;
        bus.rs_data = '0;
        bus.hazard_stall = 1'b0;
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        idle(3);
        cycle(1'b1, mk(OP_BZ, 6'h3C), 16'h0, 1'b0, 1'b0);
        idle(4);
        chk("cnt_after_bz", 32'(bus.taken_count), 32'd1);
        cycle(1'b1, mk(OP_BNZ, 6'h05), 16'h0, 1'b0, 1'b0);
        idle(2);
        cycle(1'b1, mk(OP_BZ, 6'h11), 16'h0, 1'b1, 1'b0);
        cycle(1'b1, mk(OP_BZ, 6'h11), 16'h0, 1'b1, 1'b0);
        cycle(1'b1, mk(OP_BZ, 6'h11), 16'h0, 1'b0, 1'b0);
        idle(4);
        cycle(1'b1, mk(OP_JMP, 6'h1F), 16'h0, 1'b0, 1'b0);
        cycle(1'b1, mk(OP_BZ, 6'h22), 16'h0, 1'b0, 1'b0);
        cycle(1'b1, mk(OP_BZ, 6'h23), 16'h0, 1'b1, 1'b0);
        idle(3);
        chk("cnt_after_shadow", 32'(bus.taken_count), 32'd3);
        cycle(1'b1, mk(OP_BNZ, 6'h20), 16'h5, 1'b0, 1'b0);
        idle(4);
        cycle(1'b1, mk(OP_BZ, 6'h01), 16'h7, 1'b0, 1'b0);
        cycle(1'b1, mk(4'h3, 6'h01), 16'h0, 1'b0, 1'b0);
        cycle(1'b0, mk(OP_JMP, 6'h02), 16'h0, 1'b0, 1'b0);
        idle(1);
        cycle(1'b1, mk(OP_JMP, 6'h2A), 16'h0, 1'b0, 1'b0);
        idle(2);
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        idle(3);
        for (int i = 0; i < 300; i++) begin
            logic [3:0] op;
            op = 4'h7 + 4'($urandom_range(0, 4));
            cycle(1'($urandom_range(0, 3) != 0), {op, 6'($urandom), 6'($urandom)},
                  $urandom_range(0, 1) != 0 ? 16'h0 : 16'($urandom), $urandom_range(0, 4) == 0,
                  $urandom_range(0, 60) == 0);
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
